// File: rtl/sr_flag_pkg.sv
// Shared types and default sizes for the SR flag bank.
// Report FSM states are defined here so every file uses the same encoding.
package sr_flag_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REPORT = 1'b1
  } state_e;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/sr_cell.sv
// One clocked SR flag bit with a registered rising-edge pulse.
// Set and reset both asserted hold the bit and raise a combinational conflict.
module sr_cell (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q,
  output logic rise,
  output logic conflict
);

  logic q_d, q_q;
  logic rise_d, rise_q;

  always_comb begin
    q_d = q_q;
    if (en && s && !r)      q_d = 1'b1;
    else if (en && !s && r) q_d = 1'b0;
    // Rise is taken against the next value, so a disabled cycle yields zero.
    rise_d = q_d & ~q_q;
  end

  assign conflict = en & s & r;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_q    <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rise_q <= rise_d;
    end
  end

  assign q    = q_q;
  assign rise = rise_q;

endmodule

// File: rtl/sr_flag_bank.sv
// Bank of SR flags with a saturating conflict counter and a valid/ready
// conflict report that captures the first offending mask and flags overflow.
module sr_flag_bank
  import sr_flag_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_rise,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic             err_valid,
  input  logic             err_ready,
  output logic [WIDTH-1:0] err_mask,
  output logic             err_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] conf_vec;
  logic             conflict;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell u_cell (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (en),
      .s        (s[i]),
      .r        (r[i]),
      .q        (q[i]),
      .rise     (q_rise[i]),
      .conflict (conf_vec[i])
    );
  end

  assign conflict = |conf_vec;

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                         cnt_d = conflict ? CNT_ONE : '0;
    else if (conflict && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;

  state_e           state_d, state_q;
  logic [WIDTH-1:0] mask_d, mask_q;
  logic             ovf_d, ovf_q;
  logic             valid_d, valid_q;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (conflict) begin
          state_d = REPORT;
          mask_d  = conf_vec;
          ovf_d   = 1'b0;
        end
      end
      REPORT: begin
        if (err_ready) begin
          // A new conflict in the accept cycle becomes the next report.
          state_d = conflict ? REPORT : IDLE;
          mask_d  = conflict ? conf_vec : '0;
          ovf_d   = 1'b0;
        end else if (conflict) begin
          ovf_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = '0;
        ovf_d   = 1'b0;
      end
    endcase
    valid_d = (state_d == REPORT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign err_valid = valid_q;
  assign err_mask  = mask_q;
  assign err_ovf   = ovf_q;

endmodule

// File: tb/tb_sr_flag_bank.sv
// Directed bench for sr_flag_bank: a default instance plus a CNT_W=2
// instance sharing the same stimulus for counter saturation.
module tb_sr_flag_bank;

  logic       clk = 1'b0;
  logic       reset_n, en, cnt_clr, err_ready;
  logic [7:0] s, r;
  logic [7:0] q, q_rise, err_mask, cnt;
  logic       err_valid, err_ovf;
  logic [7:0] q2, q_rise2, err_mask2;
  logic [1:0] cnt2;
  logic       err_valid2, err_ovf2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sr_flag_bank u_dut (
    .clk(clk), .reset_n(reset_n), .en(en), .s(s), .r(r), .cnt_clr(cnt_clr),
    .q(q), .q_rise(q_rise), .conflict_cnt(cnt), .err_valid(err_valid),
    .err_ready(err_ready), .err_mask(err_mask), .err_ovf(err_ovf)
  );

  sr_flag_bank #(.WIDTH(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .en(en), .s(s), .r(r), .cnt_clr(cnt_clr),
    .q(q2), .q_rise(q_rise2), .conflict_cnt(cnt2), .err_valid(err_valid2),
    .err_ready(err_ready), .err_mask(err_mask2), .err_ovf(err_ovf2)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_report(input string tag, input logic v, input logic [7:0] m,
                            input logic o, input logic [7:0] c);
    chk({tag, ".valid"}, {7'd0, err_valid}, {7'd0, v});
    chk({tag, ".mask"},  err_mask, m);
    chk({tag, ".ovf"},   {7'd0, err_ovf}, {7'd0, o});
    chk({tag, ".cnt"},   cnt, c);
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; s = '0; r = '0; cnt_clr = 1'b0; err_ready = 1'b0;
    tick();
    tick();
    chk("rst.q", q, 8'h00);
    chk("rst.rise", q_rise, 8'h00);
    chk_report("rst", 1'b0, 8'h00, 1'b0, 8'd0);

    // Basic set, then rise pulse drops after one cycle.
    reset_n = 1'b1; en = 1'b1; s = 8'h0F;
    tick();
    chk("set.q", q, 8'h0F);
    chk("set.rise", q_rise, 8'h0F);
    s = 8'h00;
    tick();
    chk("hold.q", q, 8'h0F);
    chk("hold.rise", q_rise, 8'h00);

    // Reset low between edges must do nothing.
    reset_n = 1'b0;
    #2;
    chk("async.q", q, 8'h0F);
    reset_n = 1'b1;
    tick();
    chk("async.q2", q, 8'h0F);

    // Disabled: no update and no conflict.
    en = 1'b0; s = 8'hFF; r = 8'hFF;
    tick();
    chk("dis.q", q, 8'h0F);
    chk("dis.rise", q_rise, 8'h00);
    chk_report("dis", 1'b0, 8'h00, 1'b0, 8'd0);

    // First conflict captured.
    en = 1'b1; s = 8'h81; r = 8'h81;
    tick();
    chk("c1.q", q, 8'h0F);
    chk_report("c1", 1'b1, 8'h81, 1'b0, 8'd1);

    // Second conflict while pending: overflow, mask kept.
    s = 8'h02; r = 8'h02;
    tick();
    chk("c2.q", q, 8'h0F);
    chk_report("c2", 1'b1, 8'h81, 1'b1, 8'd2);

    // Stall with no conflict holds everything.
    s = 8'h00; r = 8'h00;
    tick();
    chk_report("stall", 1'b1, 8'h81, 1'b1, 8'd2);

    // Accept together with a new conflict reloads the report.
    s = 8'h10; r = 8'h10; err_ready = 1'b1;
    tick();
    chk_report("hsc", 1'b1, 8'h10, 1'b0, 8'd3);

    // Plain accept returns to idle.
    s = 8'h00; r = 8'h00;
    tick();
    chk_report("hs", 1'b0, 8'h00, 1'b0, 8'd3);
    err_ready = 1'b0;

    // Mixed set/reset, then fill all bits.
    s = 8'hF0; r = 8'h0F;
    tick();
    chk("mix.q", q, 8'hF0);
    chk("mix.rise", q_rise, 8'hF0);
    s = 8'hFF; r = 8'h00;
    tick();
    chk("fill.q", q, 8'hFF);
    chk("fill.rise", q_rise, 8'h0F);

    // Reset mid-report wins over a conflict in the same cycle.
    s = 8'h01; r = 8'h01;
    tick();
    chk_report("c4", 1'b1, 8'h01, 1'b0, 8'd4);
    reset_n = 1'b0; s = 8'hFF; r = 8'hFF; err_ready = 1'b1; cnt_clr = 1'b0;
    tick();
    chk("rst2.q", q, 8'h00);
    chk("rst2.rise", q_rise, 8'h00);
    chk_report("rst2", 1'b0, 8'h00, 1'b0, 8'd0);
    chk("rst2.cnt2", {6'd0, cnt2}, 8'd0);

    // Saturation on the narrow counter; wide counter keeps going.
    reset_n = 1'b1; err_ready = 1'b0; s = 8'h01; r = 8'h01;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("sat%0d.cnt2", i), {6'd0, cnt2}, (i > 3) ? 8'd3 : 8'(i));
    end
    chk("sat.cnt", cnt, 8'd5);

    // Clear coincident with a conflict leaves one, clear alone gives zero.
    cnt_clr = 1'b1;
    tick();
    chk("clrc.cnt2", {6'd0, cnt2}, 8'd1);
    chk("clrc.cnt", cnt, 8'd1);
    s = 8'h00; r = 8'h00;
    tick();
    chk("clr.cnt2", {6'd0, cnt2}, 8'd0);
    chk("clr.cnt", cnt, 8'd0);
    cnt_clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sr_flag_bank.md
SR_FLAG_BANK -- requirements
Module: sr_flag_bank

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the number of flag bits.
REQ-002 Parameter CNT_W, default 8, SHALL set the conflict-counter width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the synchronous, active-low reset.
REQ-005 en  input  1  SHALL be the update enable; when 0, every bit holds.
REQ-006 s  input  WIDTH  SHALL be the per-bit set request.
REQ-007 r  input  WIDTH  SHALL be the per-bit reset request.
REQ-008 cnt_clr  input  1  SHALL clear conflict_cnt.
REQ-009 q  output  WIDTH  SHALL be the registered flag state.
REQ-010 q_rise  output  WIDTH  SHALL be a one-cycle pulse per bit that went 0->1 on the last edge.
REQ-011 conflict_cnt  output  CNT_W  SHALL count conflict cycles.
REQ-012 err_valid  output  1  SHALL indicate a pending conflict report.
REQ-013 err_ready  input  1  SHALL be the consumer acceptance of the report.
REQ-014 err_mask  output  WIDTH  SHALL be the bits that conflicted in the captured cycle.
REQ-015 err_ovf  output  1  SHALL flag that further conflicts occurred while a report was pending.

Function
REQ-016 With en=1, per bit: s=1,r=0 -> q=1; s=0,r=1 -> q=0; s=0,r=0 -> hold; s=1,r=1 -> hold and mark the bit conflicted.
REQ-017 With en=0, q SHALL hold and no conflict SHALL be detected regardless of s/r.
REQ-018 q SHALL reflect inputs with one-cycle latency (registered on the edge that samples them).
REQ-019 A conflict cycle is any cycle with en=1 and at least one bit with s=r=1.
REQ-020 conflict_cnt SHALL increment by exactly 1 per conflict cycle, independent of the number of conflicting bits, and SHALL saturate at 2^CNT_W-1.
REQ-021 cnt_clr=1 SHALL set conflict_cnt to 0, or to 1 if the same cycle is a conflict cycle.
REQ-022 The report FSM SHALL have states IDLE and REPORT; err_valid=1 exactly in REPORT.
REQ-023 IDLE -> REPORT on a conflict cycle; err_mask captures the conflicting bits; err_ovf=0.
REQ-024 In REPORT, with no handshake, a conflict cycle SHALL set err_ovf=1 and leave err_mask unchanged.
REQ-025 Handshake (err_valid & err_ready) without a same-cycle conflict SHALL return to IDLE and clear err_mask and err_ovf.
REQ-026 Handshake coincident with a conflict cycle SHALL stay in REPORT, load the new mask, and clear err_ovf.
REQ-027 err_valid, err_mask and err_ovf SHALL stay stable while err_valid=1 and err_ready=0, except for err_ovf setting per REQ-024.
REQ-028 q_rise SHALL be q & ~q_previous, registered, so it is zero whenever en=0 was sampled on the previous edge.

Reset
REQ-029 reset_n=0 at a clock edge SHALL force q=0, q_rise=0, conflict_cnt=0, err_mask=0, err_ovf=0, and state IDLE (err_valid=0).
REQ-030 reset_n SHALL take priority over en, s/r, cnt_clr and the handshake, including mid-report; no conflict is counted in a reset cycle.
REQ-031 Between edges, reset_n SHALL have no effect (no asynchronous path).

Structure
REQ-032 Package sr_flag_pkg SHALL hold the FSM state typedef (IDLE, REPORT) and the default WIDTH/CNT_W constants.
REQ-033 Sub-module sr_cell SHALL implement one clocked SR bit with synchronous active-low reset, en, and a combinational conflict output, instantiated WIDTH times; counter and FSM SHALL live in sr_flag_bank.

Verification
REQ-034 Reset then en=1, s=8'h0F, r=0 -> next edge q=8'h0F and q_rise=8'h0F; following cycle with s=r=0 -> q_rise=0, q=8'h0F.
REQ-035 en=0, s=8'hFF, r=8'hFF -> q unchanged, conflict_cnt unchanged, err_valid stays 0.
REQ-036 en=1, s=r=8'h81, err_ready=0 -> err_valid=1, err_mask=8'h81, conflict_cnt=1; second conflict on 8'h02 -> err_mask=8'h81, err_ovf=1, conflict_cnt=2.
REQ-037 In REPORT, err_ready=1 together with a conflict on 8'h10 -> err_valid stays 1, err_mask=8'h10, err_ovf=0.
REQ-038 CNT_W=2, five consecutive conflict cycles -> conflict_cnt=3; then cnt_clr=1 with a conflict -> conflict_cnt=1.
REQ-039 reset_n=0 while err_valid=1 and q=8'hFF -> after the edge all outputs are 0 and the state is IDLE.
